// File: rtl/frame_cfg_pkg.sv
// Shared types and header field layout for the fabric configuration sequencer.
package frame_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    STROBE
  } seqState_e;

  localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

  localparam int DESYNC_BIT = 31;
  localparam int COL_LSB    = 16;
  localparam int COL_W      = 8;
  localparam int FRAME_LSB  = 0;
  localparam int FRAME_W    = 8;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decoder from (column, frame) to the fabric FrameStrobe lines.
module frame_strobe_decoder
  import frame_cfg_pkg::*;
#(
  parameter int MaxFramesPerCol = 32,
  parameter int NumberOfCols    = 4
) (
  input  logic                                    CLK,
  input  logic                                    reset,
  input  logic [COL_W-1:0]                        col,
  input  logic [FRAME_W-1:0]                      frame,
  input  logic                                    enable,
  input  logic                                    skip,
  output logic [NumberOfCols*MaxFramesPerCol-1:0] strobe
);

  logic [NumberOfCols*MaxFramesPerCol-1:0] strobeNext;

  // Out-of-range addresses never match any line, but skip also gates them explicitly.
  for (genvar c = 0; c < NumberOfCols; c++) begin : gCol
    for (genvar f = 0; f < MaxFramesPerCol; f++) begin : gFrame
      assign strobeNext[c*MaxFramesPerCol+f] = enable && !skip &&
                                               (col == COL_W'(c)) && (frame == FRAME_W'(f));
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) strobe <= '0;
    else       strobe <= strobeNext;
  end

endmodule

// File: rtl/frame_config_sequencer.sv
// Bitstream-to-ConfigMem sequencer: sync detect, header parse, row assembly, one-shot strobe.
module frame_config_sequencer
  import frame_cfg_pkg::*;
#(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 32,
  parameter int          NumberOfRows    = 4,
  parameter int          NumberOfCols    = 4,
  parameter logic [31:0] SyncWord        = SYNC_WORD
) (
  input  logic                                    CLK,
  input  logic                                    reset,
  input  logic [31:0]                             s_data,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                    ConfigActive,
  output logic                                    AddrError
);

  localparam int ROW_W = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;

  seqState_e state, stateNext;

  logic [ROW_W-1:0]                              rowCnt;
  logic [COL_W-1:0]                              colQ;
  logic [FRAME_W-1:0]                            frameQ;
  logic                                          skipQ;
  logic [NumberOfRows-1:0][FrameBitsPerRow-1:0]  rowData;

  logic               accept;
  logic               strobeEn;
  logic               lastRow;
  logic               hdrDesync;
  logic [COL_W-1:0]   hdrCol;
  logic [FRAME_W-1:0] hdrFrame;
  logic               hdrBad;

  assign accept    = s_valid && s_ready;
  assign lastRow   = (rowCnt == ROW_W'(NumberOfRows - 1));
  assign hdrDesync = s_data[DESYNC_BIT];
  assign hdrCol    = s_data[COL_LSB +: COL_W];
  assign hdrFrame  = s_data[FRAME_LSB +: FRAME_W];
  assign hdrBad    = (32'(hdrCol) >= NumberOfCols) || (32'(hdrFrame) >= MaxFramesPerCol);

  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // s_ready depends on state only; the strobe enable fires on the last-row handshake
  // so the registered decoder output lines up with the STROBE cycle.
  always_comb begin
    stateNext = state;
    s_ready   = 1'b1;
    strobeEn  = 1'b0;
    case (state)
      IDLE:   if (accept && s_data == SyncWord) stateNext = HEADER;
      HEADER: if (accept) stateNext = hdrDesync ? IDLE : DATA;
      DATA: begin
        if (accept && lastRow) begin
          stateNext = STROBE;
          strobeEn  = 1'b1;
        end
      end
      STROBE: begin
        s_ready   = 1'b0;
        stateNext = HEADER;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      rowCnt       <= '0;
      colQ         <= '0;
      frameQ       <= '0;
      skipQ        <= 1'b0;
      rowData      <= '0;
      ConfigActive <= 1'b0;
      AddrError    <= 1'b0;
    end else if (accept) begin
      case (state)
        IDLE: if (s_data == SyncWord) ConfigActive <= 1'b1;
        HEADER: begin
          if (hdrDesync) begin
            ConfigActive <= 1'b0;
          end else begin
            colQ   <= hdrCol;
            frameQ <= hdrFrame;
            skipQ  <= hdrBad;
            rowCnt <= '0;
            if (hdrBad) AddrError <= 1'b1;
          end
        end
        DATA: begin
          rowData[rowCnt] <= s_data[FrameBitsPerRow-1:0];
          rowCnt          <= rowCnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign FrameData = rowData;

  frame_strobe_decoder #(
    .MaxFramesPerCol(MaxFramesPerCol),
    .NumberOfCols   (NumberOfCols)
  ) uDecoder (
    .CLK   (CLK),
    .reset (reset),
    .col   (colQ),
    .frame (frameQ),
    .enable(strobeEn),
    .skip  (skipQ),
    .strobe(FrameStrobe)
  );

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Scoreboard bench: drivers push expected strobe events, a negedge monitor pops and checks them.
module tb_frame_config_sequencer;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int MFPC = 32;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic                 CLK = 1'b0;
  logic                 reset = 1'b1;
  logic [31:0]          s_data = '0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [ROWS*32-1:0]   FrameData;
  logic [COLS*MFPC-1:0] FrameStrobe;
  logic                 ConfigActive;
  logic                 AddrError;

  frame_config_sequencer dut (
    .CLK         (CLK),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .ConfigActive(ConfigActive),
    .AddrError   (AddrError)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int           idx;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t expQ[$];
  int   strobeCyc[$];

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every nonzero strobe must match the oldest expected event.
  always @(negedge CLK) begin : mon
    exp_t e;
    int   idx;
    if (!reset && FrameStrobe != '0) begin
      strobeCyc.push_back(cyc);
      idx = -1;
      for (int i = 0; i < COLS*MFPC; i++) if (FrameStrobe[i]) idx = i;
      if (expQ.size() == 0) begin
        chk("unexpected strobe", 128'(FrameStrobe), 128'(0));
      end else begin
        e = expQ.pop_front();
        chk("strobe onehot", 128'($countones(FrameStrobe)), 128'(1));
        chk("strobe index", 128'(idx), 128'(e.idx));
        chk("strobe cycle", 128'(cyc), 128'(e.cyc));
        chk("data at strobe", FrameData, e.data);
        chk("s_ready in strobe", 128'(s_ready), 128'(0));
      end
    end
  end

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Holds s_valid until accepted; returns 1 time unit after the accepting edge.
  task automatic sendWord(input logic [31:0] w);
    int waited = 0;
    bit done = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (!done) begin
      @(negedge CLK);
      if (s_ready) done = 1;
      else if (++waited > 20) begin
        chk("handshake timeout", 128'(0), 128'(1));
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic sendFrame(input int col, input int frame, input logic [127:0] data,
                           input bit stallMid);
    logic [31:0] hdr;
    hdr = '0;
    hdr[23:16] = col[7:0];
    hdr[7:0]   = frame[7:0];
    sendWord(hdr);
    for (int r = 0; r < ROWS; r++) begin
      sendWord(data[r*32 +: 32]);
      if (stallMid && r == 1) idle(2);
    end
    if (col < COLS && frame < MFPC) expQ.push_back('{col*MFPC + frame, data, cyc});
    chk("FrameData after frame", FrameData, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    // Reset state
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
    chk("reset s_ready", 128'(s_ready), 128'(1));
    chk("reset FrameData", FrameData, 128'(0));
    chk("reset FrameStrobe", 128'(FrameStrobe), 128'(0));
    chk("reset ConfigActive", 128'(ConfigActive), 128'(0));
    chk("reset AddrError", 128'(AddrError), 128'(0));

    // Junk before sync is discarded
    sendWord(32'hDEADBEEF);
    sendWord(32'h12345678);
    idle(2);
    chk("junk ConfigActive", 128'(ConfigActive), 128'(0));

    // First frame, with a mid-frame stall
    sendWord(SYNC);
    chk("sync ConfigActive", 128'(ConfigActive), 128'(1));
    sendFrame(2, 5, 128'h44444444_33333333_22222222_11111111, 1'b1);
    idle(3);
    chk("frame1 strobes seen", 128'(strobeCyc.size()), 128'(1));

    // Back-to-back frames
    n0 = strobeCyc.size();
    sendFrame(0, 0,  128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0, 1'b0);
    sendFrame(3, 31, 128'hB0000003_B0000002_B0000001_FAB0FAB1, 1'b0);
    sendFrame(1, 17, 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0, 1'b0);
    idle(3);
    chk("b2b strobe count", 128'(strobeCyc.size() - n0), 128'(3));
    if (strobeCyc.size() >= n0 + 3) begin
      chk("b2b gap 1", 128'(strobeCyc[n0+1] - strobeCyc[n0]), 128'(6));
      chk("b2b gap 2", 128'(strobeCyc[n0+2] - strobeCyc[n0+1]), 128'(6));
    end

    // Out-of-range headers: data lands, no strobe, sticky error
    sendFrame(4, 0, 128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1, 1'b0);
    chk("col oob AddrError", 128'(AddrError), 128'(1));
    sendFrame(0, 32, 128'hE4E4E4E4_E3E3E3E3_E2E2E2E2_E1E1E1E1, 1'b0);
    sendFrame(1, 2, 128'h0F0F0F0F_0E0E0E0E_0D0D0D0D_0C0C0C0C, 1'b0);
    idle(3);
    chk("AddrError sticky", 128'(AddrError), 128'(1));

    // Desync, then data-looking words are ignored in IDLE
    sendWord(32'h8000_0000);
    chk("desync ConfigActive", 128'(ConfigActive), 128'(0));
    sendWord(32'h0002_0005);
    for (int i = 0; i < ROWS; i++) sendWord(32'h1111_1111 * (i + 1));
    idle(3);
    chk("post-desync ConfigActive", 128'(ConfigActive), 128'(0));
    chk("post-desync FrameData", FrameData, 128'h0F0F0F0F_0E0E0E0E_0D0D0D0D_0C0C0C0C);

    // Reset mid-frame abandons the frame
    sendWord(SYNC);
    sendWord(32'h0001_0003);
    sendWord(32'h5555_5555);
    sendWord(32'h6666_6666);
    s_valid = 1'b0;
    reset = 1'b1;
    @(posedge CLK);
    #1 reset = 1'b0;
    chk("midreset FrameData", FrameData, 128'(0));
    chk("midreset ConfigActive", 128'(ConfigActive), 128'(0));
    chk("midreset AddrError", 128'(AddrError), 128'(0));
    chk("midreset s_ready", 128'(s_ready), 128'(1));
    idle(3);
    sendWord(SYNC);
    sendFrame(3, 7, 128'h99999999_88888888_77777777_12121212, 1'b0);
    idle(3);

    chk("pending strobes", 128'(expQ.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
